multi_lane_data_receiver: RTL
=============================

Name: multi_lane_data_receiver

Overview:
Parametrised successor to the single-lane serial data receiver in the network path. Hunts for a per-lane sync word on LANES parallel serial inputs and deserialises a DATA_BITS payload striped across lanes. Presents the payload on a valid/ready handshake and flags lane sync mismatch and hunt timeout. Sits between the board-to-board serial pins and the network packet decoder.

Parameters:
DATA_BITS, 216 (ENC_DATA_BITS), payload width; must be divisible by LANES, else elaboration $fatal
LANES, 4, number of serial lanes; 1 is legal
SYNC_BITS, 8, sync word length per lane
SYNC_WORD, 8'hA5, pattern each lane must present (SYNC_BITS wide)
TIMEOUT_CYCLES, 1024, hunt cycles before giving up; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
receive_start  in  1  single-cycle arm request
serial_in  in  LANES  serial bit per lane, sampled on posedge clk
data_out  out  DATA_BITS  received payload; stable while data_valid
data_valid  out  1  payload available
data_ready  in  1  consumer accepts payload when data_valid & data_ready
busy  out  1  high in HUNT, RECEIVE, DONE
sync_err  out  1  one-cycle pulse: lane sync mismatch
timeout  out  1  one-cycle pulse: hunt expired

Behaviour:
- Reset: state IDLE; data_out 0, data_valid 0, busy 0, sync_err 0, timeout 0; lane shift regs, beat counter and hunt counter 0.
- Per lane k: sync_reg[k] shifts serial_in[k] in LSB-side every cycle in all states. match[k] = ({sync_reg[k][SYNC_BITS-2:0], serial_in[k]} == SYNC_WORD), i.e. includes the bit being sampled this edge.
- W = DATA_BITS/LANES beats.
- IDLE: receive_start -> HUNT, hunt counter cleared. Otherwise remain.
- HUNT:
  - all match -> RECEIVE, beat counter 0.
  - some but not all match -> sync_err pulses the next cycle; remain in HUNT.
  - Otherwise hunt counter increments. On reaching TIMEOUT_CYCLES-1 without a full match -> IDLE, timeout pulses.
  - Full match on the timeout cycle wins; no timeout pulse.
  - receive_start is ignored.
- RECEIVE: payload bits sampled on the W edges following the sync edge. On beat j, lane k bit goes to data_out[DATA_BITS-1-(j*LANES+k)] (MSB first, lane-interleaved). Assemble in an internal shift register; data_out changes only on the final beat.
  - On beat W-1: data_out loaded, state -> DONE, data_valid 1 from the next cycle.
  - Latency: last sync bit sampled at edge E -> data_valid visible after edge E+W.
  - receive_start, sync matches and mismatches are ignored.
- DONE: data_valid held with data_out stable until data_ready.
  - Handshake cycle -> IDLE, data_valid 0 next cycle.
  - Handshake plus receive_start in the same cycle -> HUNT directly.
  - receive_start without data_ready is ignored.
- busy = (state != IDLE), registered with state.
- rst mid-frame: partial payload discarded; all outputs return to reset values on the next edge.
- SYNC_WORD appearing inside the payload has no effect; detection is active only in HUNT.

Decomposition:
- NetworkPkg: rx_state_t enum {RX_IDLE, RX_HUNT, RX_RECEIVE, RX_DONE}; SYNC_WORD default constant (RX_SYNC_WORD); reuse ENC_DATA_BITS.
- Sub-module lane_sync_detector (params SYNC_BITS, SYNC_WORD; ports clk, rst, serial_in, match). Instantiated LANES times via generate.
- Deserialise and FSM stay in the top.

Test Plan:
- LANES=1, DATA_BITS=216, SYNC_WORD=8'hA5: pulse start, drive 0xA5 then {108{2'b10}} -> data_valid exactly 216 cycles after the last sync bit edge; data_out == {108{2'b10}}; busy high throughout.
- LANES=4, DATA_BITS=216: stripe payload 216'h…0123456789ABCDEF per the index rule; hold data_ready 0 for 5 cycles -> data_valid and data_out stable; handshake -> IDLE, busy 0.
- LANES=4: lanes 0-2 send 0xA5, lane 3 sends 0xA4 -> sync_err one-cycle pulse, still HUNT. Resend aligned 0xA5 on all lanes -> normal receive.
- TIMEOUT_CYCLES=16: start with idle-low lines -> timeout pulse 16 cycles after entering HUNT, state IDLE. Repeat with TIMEOUT_CYCLES=0 -> no timeout after 5000 cycles.
- Payload containing 0xA5 at several offsets -> data_out correct, no early termination, no sync_err.
- Assert rst at beat 100 of a frame -> data_valid 0, busy 0 next cycle. Handshake plus simultaneous receive_start in DONE -> HUNT, second frame received correctly.

Source files
------------

// File: rtl/multi_lane_data_receiver_pkg.sv
// Shared types and constants for the multi-lane serial receiver.
package multi_lane_data_receiver_pkg;

  localparam int unsigned ENC_DATA_BITS = 216;
  localparam int unsigned RX_SYNC_BITS  = 8;
  localparam logic [RX_SYNC_BITS-1:0] RX_SYNC_WORD = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HUNT,
    RX_RECEIVE,
    RX_DONE
  } rx_state_t;

endpackage

// File: rtl/lane_sync_detector.sv
// Per-lane sync word detector: shift history plus a combinational compare that
// includes the bit being sampled on the current edge.
module lane_sync_detector #(
  parameter int unsigned SYNC_BITS = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic match
);

  if (SYNC_BITS < 2) begin : g_bad_sync_bits
    $fatal(1, "lane_sync_detector: SYNC_BITS must be at least 2");
  end

  // Only the older SYNC_BITS-1 bits need storing; the newest comes from the pin.
  logic [SYNC_BITS-2:0] sync_q;

  // History shifts every cycle regardless of receiver state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= (SYNC_BITS-1)'({sync_q, serial_in});
    end
  end

  assign match = ({sync_q, serial_in} == SYNC_WORD);

endmodule

// File: rtl/multi_lane_data_receiver.sv
// Multi-lane serial receiver: hunts for a sync word on every lane, then
// deserialises a lane-interleaved, MSB-first payload onto a valid/ready port.
module multi_lane_data_receiver
  import multi_lane_data_receiver_pkg::*;
#(
  parameter int unsigned DATA_BITS      = ENC_DATA_BITS,
  parameter int unsigned LANES          = 4,
  parameter int unsigned SYNC_BITS      = RX_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD = SYNC_BITS'(RX_SYNC_WORD),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 receive_start,
  input  logic [LANES-1:0]     serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 sync_err,
  output logic                 timeout
);

  if ((LANES == 0) || (DATA_BITS % LANES != 0)) begin : g_bad_lanes
    $fatal(1, "multi_lane_data_receiver: DATA_BITS must be divisible by LANES");
  end

  localparam int unsigned BEATS  = DATA_BITS / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned HUNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [HUNT_W-1:0] HUNT_LAST =
    HUNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  rx_state_t             state_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [HUNT_W-1:0]     hunt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [DATA_BITS-1:0]  shift_d;
  logic [DATA_BITS-1:0]  data_out_q;
  logic                  data_valid_q;
  logic                  busy_q;
  logic                  sync_err_q;
  logic                  timeout_q;

  logic [LANES-1:0]      match;
  logic [LANES-1:0]      lane_bits_c;

  // One detector per lane; lane k also feeds bit LANES-1-k of each beat so lane 0 lands most significant.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_sync_detector #(
      .SYNC_BITS (SYNC_BITS),
      .SYNC_WORD (SYNC_WORD)
    ) u_det (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in[k]),
      .match     (match[k])
    );
    assign lane_bits_c[LANES-1-k] = serial_in[k];
  end

  // Earlier beats move toward the MSB as each new beat is appended.
  assign shift_d = (shift_q << LANES) | DATA_BITS'(lane_bits_c);

  // Receiver FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      beat_q       <= '0;
      hunt_q       <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      sync_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (receive_start) begin
            state_q <= RX_HUNT;
            busy_q  <= 1'b1;
            hunt_q  <= '0;
          end
        end
        RX_HUNT: begin
          if (&match) begin
            state_q <= RX_RECEIVE;
            beat_q  <= '0;
          end else if (|match) begin
            sync_err_q <= 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (hunt_q == HUNT_LAST)) begin
            state_q   <= RX_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (TIMEOUT_CYCLES != 0) begin
            hunt_q <= hunt_q + HUNT_W'(1);
          end
        end
        RX_RECEIVE: begin
          shift_q <= shift_d;
          beat_q  <= beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            data_out_q   <= shift_d;
            data_valid_q <= 1'b1;
            state_q      <= RX_DONE;
          end
        end
        RX_DONE: begin
          if (data_ready) begin
            data_valid_q <= 1'b0;
            if (receive_start) begin
              state_q <= RX_HUNT;
              hunt_q  <= '0;
            end else begin
              state_q <= RX_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign sync_err   = sync_err_q;
  assign timeout    = timeout_q;

endmodule
